// File: rtl/mem_ext_arbiter_if.sv
// Request, response and macro-side signals of the SRAM port arbiter.
// The slave modport is the arbiter's view; the master modport is the client/macro side.
interface mem_ext_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 256,
   parameter int MASK_W  = 32,
   parameter int ID_W    = 1
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*MASK_W-1:0] req_wmask;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [ID_W-1:0]           resp_id;
   logic [DATA_W-1:0]         resp_data;
   logic                      mem_en;
   logic                      mem_wmode;
   logic [ADDR_W-1:0]         mem_addr;
   logic [MASK_W-1:0]         mem_wmask;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_id, resp_data,
      output mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_id, resp_data,
      input  mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/mem_ext_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between NUM_REQ clients,
// with a one-entry hold buffer so the read consumer can backpressure.
module mem_ext_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 256,
   parameter int MASK_W  = 32,
   parameter int ID_W    = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   mem_ext_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [ID_W-1:0]     gnt_idx;
   logic                gnt_found;
   logic                gnt_read;
   logic                read_ok;
   logic [NUM_REQ-1:0]  elig;

   // A read may only issue when the response slot frees up this cycle; writes always may.
   assign read_ok = (state_q == IDLE) | bus.resp_ready;
   assign elig    = reset_n ? (bus.req_valid & (bus.req_write | {NUM_REQ{read_ok}})) : '0;

   always_comb begin
      gnt_found     = 1'b0;
      gnt_idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && elig[i] && ((int'(rr_ptr_q) + k) % NUM_REQ == i)) begin
               gnt_found = 1'b1;
               gnt_idx   = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      bus.mem_en    = 1'b0;
      bus.mem_wmode = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wmask = '0;
      bus.mem_wdata = '0;
      gnt_read      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_found && (gnt_idx == ID_W'(i))) begin
            bus.req_ready[i] = 1'b1;
            bus.mem_en       = 1'b1;
            bus.mem_wmode    = bus.req_write[i];
            bus.mem_addr     = bus.req_addr[i*ADDR_W +: ADDR_W];
            bus.mem_wmask    = bus.req_wmask[i*MASK_W +: MASK_W];
            bus.mem_wdata    = bus.req_wdata[i*DATA_W +: DATA_W];
            gnt_read         = ~bus.req_write[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      hold_d   = hold_q;
      if (gnt_found) begin
         rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
      if (gnt_read) begin
         id_d = gnt_idx;
      end
      case (state_q)
         IDLE: begin
            if (gnt_read) state_d = WAIT;
         end
         WAIT, HOLD: begin
            if (bus.resp_ready) begin
               state_d = gnt_read ? WAIT : IDLE;
            end else begin
               state_d = HOLD;
               // Capture once on entry; later macro writes cannot disturb the held word.
               if (state_q == WAIT) hold_d = bus.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         hold_q   <= hold_d;
      end
   end

   assign bus.resp_valid = (state_q != IDLE);
   assign bus.resp_id    = id_q;
   assign bus.resp_data  = (state_q == HOLD) ? hold_q : bus.mem_rdata;

endmodule

// File: tb/tb_mem_ext_arbiter.sv
// Directed scoreboard bench for mem_ext_arbiter with a behavioural SRAM macro model.
module tb_mem_ext_arbiter;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 19;
   localparam int DATA_W  = 256;
   localparam int MASK_W  = 32;
   localparam int ID_W    = 1;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk;
   logic reset_n;
   int   nvec;
   int   nerr;
   exp_t sb[$];
   exp_t ex;

   logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] cur;

   localparam logic [DATA_W-1:0] A5  = {32{8'hA5}};
   localparam logic [DATA_W-1:0] ONE = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] B0  = {{(DATA_W-8){1'b0}}, 8'hFF};

   mem_ext_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .MASK_W(MASK_W), .ID_W(ID_W)) bif ();

   mem_ext_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .MASK_W(MASK_W), .ID_W(ID_W)) dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Macro model: registered read, masked write, read data unchanged by writes.
   initial bif.mem_rdata = '0;
   always @(posedge clk) begin
      if (bif.mem_en) begin
         cur = mem_arr.exists(bif.mem_addr) ? mem_arr[bif.mem_addr] : '0;
         if (bif.mem_wmode) begin
            for (int b = 0; b < MASK_W; b++)
               if (bif.mem_wmask[b]) cur[b*8 +: 8] = bif.mem_wdata[b*8 +: 8];
            mem_arr[bif.mem_addr] = cur;
         end else begin
            bif.mem_rdata <= cur;
         end
      end
   end

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int i, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
      bif.req_valid[i]                 = v;
      bif.req_write[i]                 = w;
      bif.req_addr[i*ADDR_W +: ADDR_W] = a;
      bif.req_wmask[i*MASK_W +: MASK_W] = m;
      bif.req_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic idle_reqs();
      for (int i = 0; i < NUM_REQ; i++) drv(i, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Sample at the falling edge; retire any response handed over this cycle.
   task automatic sample();
      @(negedge clk);
      if (bif.resp_valid && bif.resp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            ex = sb.pop_front();
            chk("resp_id", DATA_W'(bif.resp_id), DATA_W'(ex.id));
            chk("resp_data", bif.resp_data, ex.data);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
      ex.id   = id;
      ex.data = d;
      sb.push_back(ex);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      reset_n = 1'b0;
      bif.resp_ready = 1'b1;
      idle_reqs();
      drv(0, 1'b1, 1'b0, 19'h10, '0, '0);
      drv(1, 1'b1, 1'b0, 19'h10, '0, '0);
      adv();
      sample();
      chk("rst_req_ready", DATA_W'(bif.req_ready), 0);
      chk("rst_mem_en", DATA_W'(bif.mem_en), 0);
      chk("rst_resp_valid", DATA_W'(bif.resp_valid), 0);
      adv();
      reset_n = 1'b1;
      idle_reqs();

      // T1: write then read back
      drv(0, 1'b1, 1'b1, 19'h10, '1, A5);
      sample();
      chk("t1_wr_ready", DATA_W'(bif.req_ready), 1);
      chk("t1_wr_mode", DATA_W'(bif.mem_wmode), 1);
      chk("t1_wr_addr", DATA_W'(bif.mem_addr), 'h10);
      adv();
      drv(0, 1'b1, 1'b0, 19'h10, '0, '0);
      sample();
      chk("t1_rd_ready", DATA_W'(bif.req_ready), 1);
      chk("t1_rd_mode", DATA_W'(bif.mem_wmode), 0);
      push(0, A5);
      adv();
      idle_reqs();
      sample();
      chk("t1_resp_valid", DATA_W'(bif.resp_valid), 1);
      adv();

      // T2: fairness after reset
      reset_n = 1'b0;
      adv();
      reset_n = 1'b1;
      drv(0, 1'b1, 1'b0, 19'h10, '0, '0);
      drv(1, 1'b1, 1'b0, 19'h10, '0, '0);
      for (int k = 0; k < 6; k++) begin
         sample();
         chk($sformatf("t2_grant%0d", k), DATA_W'(bif.req_ready), (k % 2) ? 2 : 1);
         push(ID_W'(k % 2), A5);
         adv();
      end
      idle_reqs();
      sample();
      adv();

      // T3: backpressure with a write to the same address while held
      drv(0, 1'b1, 1'b0, 19'h10, '0, '0);
      sample();
      chk("t3_rd_ready", DATA_W'(bif.req_ready), 1);
      push(0, A5);
      adv();
      bif.resp_ready = 1'b0;
      drv(1, 1'b1, 1'b1, 19'h10, '1, ONE);
      for (int k = 0; k < 3; k++) begin
         sample();
         chk($sformatf("t3_valid%0d", k), DATA_W'(bif.resp_valid), 1);
         chk($sformatf("t3_data%0d", k), bif.resp_data, A5);
         chk($sformatf("t3_ready%0d", k), DATA_W'(bif.req_ready), 2);
         chk($sformatf("t3_wmode%0d", k), DATA_W'(bif.mem_wmode), 1);
         adv();
      end
      bif.resp_ready = 1'b1;
      drv(1, 1'b0, 1'b0, '0, '0, '0);
      sample();
      chk("t3_reread_ready", DATA_W'(bif.req_ready), 1);
      push(0, ONE);
      adv();
      idle_reqs();
      sample();
      adv();

      // T4: partial byte write
      drv(1, 1'b1, 1'b1, 19'h20, '1, '0);
      sample();
      chk("t4_wr0_ready", DATA_W'(bif.req_ready), 2);
      adv();
      drv(1, 1'b1, 1'b1, 19'h20, 32'h1, ONE);
      sample();
      chk("t4_wr1_mask", DATA_W'(bif.mem_wmask), 1);
      adv();
      drv(1, 1'b1, 1'b0, 19'h20, '0, '0);
      sample();
      chk("t4_rd_ready", DATA_W'(bif.req_ready), 2);
      push(1, B0);
      adv();
      idle_reqs();
      sample();
      adv();

      // T5: reset during WAIT drops the read
      drv(0, 1'b1, 1'b0, 19'h10, '0, '0);
      sample();
      adv();
      reset_n = 1'b0;
      bif.resp_ready = 1'b0;
      sample();
      chk("t5_rst_ready", DATA_W'(bif.req_ready), 0);
      chk("t5_rst_mem_en", DATA_W'(bif.mem_en), 0);
      adv();
      reset_n = 1'b1;
      bif.resp_ready = 1'b1;
      drv(1, 1'b1, 1'b0, 19'h10, '0, '0);
      sample();
      chk("t5_no_stale", DATA_W'(bif.resp_valid), 0);
      chk("t5_rr_restart", DATA_W'(bif.req_ready), 1);
      push(0, ONE);
      adv();
      idle_reqs();
      sample();
      adv();

      // T6: idle
      for (int k = 0; k < 10; k++) begin
         sample();
         chk($sformatf("t6_mem_en%0d", k), DATA_W'(bif.mem_en), 0);
         chk($sformatf("t6_valid%0d", k), DATA_W'(bif.resp_valid), 0);
         adv();
      end

      chk("sb_empty", DATA_W'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
